// File: rtl/vfp_pattern_frame_gen.sv
// vfp_pattern_frame_gen: raster test-pattern source. Produces active/blanked
// frames with sof/eof markers, six selectable patterns, downstream backpressure
// and a bounded or continuous frame count.
// Optional feature macro: VFP_PATGEN_LFSR_EN -- when defined, mode 3 is an
// LFSR random pattern; when undefined the LFSR is absent and mode 3 falls back
// to the incrementer pattern.
module vfp_pattern_frame_gen #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 32,
  parameter int DATA_W     = 8,
  parameter int XY_W       = 12
) (
  input  logic                clkmm,
  input  logic                reset,
  input  logic                iReadyToRead,
  input  logic [2:0]          iMode,
  input  logic [3*DATA_W-1:0] iSolidRgb,
  input  logic [15:0]         iNumFrames,
  input  logic                iDsReady,
  output logic                valid,
  output logic                lvalid,
  output logic                fvalid,
  output logic                sof,
  output logic                eof,
  output logic [3*DATA_W-1:0] rgb,
  output logic [XY_W-1:0]     x,
  output logic [XY_W-1:0]     y,
  output logic                oBusy,
  output logic [15:0]         oFrameCount,
  output logic                oDone
);

  localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BW   = $clog2(BMAX + 1);
  localparam int XE_W = XY_W + 4;
  localparam logic [XY_W-1:0] X_LAST  = XY_W'(IMG_WIDTH - 1);
  localparam logic [XY_W-1:0] Y_LAST  = XY_W'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0]   HB_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0]   VB_LAST = BW'(V_BLANK - 1);

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK, S_DONE} state_t;

  state_t              state_q;
  logic [2:0]          mode_q;
  logic [15:0]         nframes_q;
  logic [BW-1:0]       bcnt_q;
  logic [2:0]          m_new;
  logic [XY_W-1:0]     x_inc, y_inc;
  logic [3*DATA_W-1:0] rnd_seed, rnd_cur, rnd_nx;

  assign x_inc = x + 1'b1;
  assign y_inc = y + 1'b1;

  // Colour bar index: count how many precomputed bar-start thresholds x has
  // passed. Bar i starts at ceil(i*IMG_WIDTH/8), so no divider is needed.
  function automatic logic [2:0] bar_idx(input logic [XY_W-1:0] px);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (32'(px) >= 32'((i * IMG_WIDTH + 7) / 8)) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [3*DATA_W-1:0] pattern(
    input logic [2:0]          m,
    input logic [XY_W-1:0]     px,
    input logic [XY_W-1:0]     py,
    input logic [3*DATA_W-1:0] rnd,
    input logic [3*DATA_W-1:0] solid
  );
    logic [DATA_W-1:0]   cx, cy;
    logic [XE_W-1:0]     xe, ye;
    logic [2:0]          c;
    logic [3*DATA_W-1:0] res;
    cx = DATA_W'(px);
    cy = DATA_W'(py);
    xe = XE_W'(px);
    ye = XE_W'(py);
    c  = 3'd7 - bar_idx(px);
    case (m)
      3'd0:    res = {cx, cy, DATA_W'(cx + cy)};
      3'd1:    res = solid;
      3'd2:    res = {{DATA_W{c[2]}}, {DATA_W{c[1]}}, {DATA_W{c[0]}}};
      3'd3:    res = rnd;
      3'd4:    res = {cx, cx, cx};
      3'd5:    res = (xe[3] ^ ye[3]) ? '1 : '0;
      default: res = '0;
    endcase
    return res;
  endfunction

`ifdef VFP_PATGEN_LFSR_EN
  localparam logic [31:0] LFSR_SEED = 32'hACE12468;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam int          LREP      = (3 * DATA_W + 31) / 32;

  logic [31:0] lfsr_q, lfsr_nx;

  function automatic logic [31:0] lfsr_step(input logic [31:0] lf);
    return lf[0] ? ((lf >> 1) ^ LFSR_POLY) : (lf >> 1);
  endfunction

  // Wide channels take the 32-bit state replicated up to 3*DATA_W bits.
  function automatic logic [3*DATA_W-1:0] lfsr_bits(input logic [31:0] lf);
    logic [LREP*32-1:0] r;
    r = {LREP{lf}};
    return r[3*DATA_W-1:0];
  endfunction

  assign lfsr_nx  = lfsr_step(lfsr_q);
  assign rnd_seed = lfsr_bits(LFSR_SEED);
  assign rnd_cur  = lfsr_bits(lfsr_q);
  assign rnd_nx   = lfsr_bits(lfsr_nx);
  assign m_new    = iMode;

  // LFSR reseeds at run start and advances once per accepted pixel.
  always_ff @(posedge clkmm) begin
    if (reset || (state_q == S_IDLE && iReadyToRead)) lfsr_q <= LFSR_SEED;
    else if (valid && iDsReady)                        lfsr_q <= lfsr_nx;
  end
`else
  assign rnd_seed = '0;
  assign rnd_cur  = '0;
  assign rnd_nx   = '0;
  // Without the LFSR, mode 3 is latched as the incrementer.
  assign m_new    = (iMode == 3'd3) ? 3'd0 : iMode;
`endif

  // Frame sequencer; every output is computed for the next pixel and registered.
  always_ff @(posedge clkmm) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      nframes_q   <= '0;
      bcnt_q      <= '0;
      valid       <= 1'b0;
      lvalid      <= 1'b0;
      fvalid      <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      rgb         <= '0;
      x           <= '0;
      y           <= '0;
      oBusy       <= 1'b0;
      oFrameCount <= '0;
      oDone       <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state_q)
        S_IDLE: if (iReadyToRead) begin
          state_q     <= S_ACTIVE;
          mode_q      <= m_new;
          nframes_q   <= iNumFrames;
          oFrameCount <= '0;
          oBusy       <= 1'b1;
          {valid, lvalid, fvalid, sof} <= 4'b1111;
          eof         <= 1'b0;
          x           <= '0;
          y           <= '0;
          rgb         <= pattern(m_new, '0, '0, rnd_seed, iSolidRgb);
        end
        S_ACTIVE: if (iDsReady) begin
          sof <= 1'b0;
          if (x == X_LAST) begin
            state_q <= S_HBLANK;
            bcnt_q  <= '0;
            valid   <= 1'b0;
            lvalid  <= 1'b0;
            eof     <= 1'b0;
          end else begin
            x   <= x_inc;
            eof <= (x_inc == X_LAST) && (y == Y_LAST);
            rgb <= pattern(mode_q, x_inc, y, rnd_nx, iSolidRgb);
          end
        end
        S_HBLANK: if (bcnt_q == HB_LAST) begin
          bcnt_q <= '0;
          if (y == Y_LAST) begin
            state_q     <= S_VBLANK;
            fvalid      <= 1'b0;
            oFrameCount <= oFrameCount + 1'b1;
          end else begin
            state_q <= S_ACTIVE;
            valid   <= 1'b1;
            lvalid  <= 1'b1;
            x       <= '0;
            y       <= y_inc;
            rgb     <= pattern(mode_q, '0, y_inc, rnd_cur, iSolidRgb);
          end
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
        S_VBLANK: if (bcnt_q == VB_LAST) begin
          bcnt_q <= '0;
          if (nframes_q != '0 && oFrameCount == nframes_q) begin
            state_q <= S_DONE;
            oDone   <= 1'b1;
            oBusy   <= 1'b0;
            x       <= '0;
            y       <= '0;
            rgb     <= '0;
          end else begin
            state_q <= S_ACTIVE;
            mode_q  <= m_new;
            {valid, lvalid, fvalid, sof} <= 4'b1111;
            x       <= '0;
            y       <= '0;
            rgb     <= pattern(m_new, '0, '0, rnd_cur, iSolidRgb);
          end
        end else begin
          bcnt_q <= bcnt_q + 1'b1;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vfp_pattern_frame_gen.sv
// Bench for vfp_pattern_frame_gen: small 4x2 frames (plus an 8-wide instance
// for colour bars), scenario tasks checked against a pixel-list model.
module tb_vfp_pattern_frame_gen;
  localparam int W = 4, H = 2, HB = 2, VB = 3, DW = 8, XYW = 12, W8 = 8;
  localparam logic [31:0] SEED = 32'hACE12468, POLY = 32'h80200003;

  logic        clkmm = 1'b0, reset = 1'b1, iReadyToRead = 1'b0, iDsReady = 1'b1;
  logic [2:0]  iMode = 3'd0;
  logic [23:0] iSolidRgb = 24'h0;
  logic [15:0] iNumFrames = 16'd0;

  logic valid, lvalid, fvalid, sof, eof, oBusy, oDone;
  logic [23:0] rgb; logic [XYW-1:0] x, y; logic [15:0] oFrameCount;
  logic valid8, lvalid8, fvalid8, sof8, eof8, oBusy8, oDone8;
  logic [23:0] rgb8; logic [XYW-1:0] x8, y8; logic [15:0] oFrameCount8;

  int nchk = 0, nfail = 0;

  vfp_pattern_frame_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
                          .DATA_W(DW), .XY_W(XYW)) dut (
    .clkmm(clkmm), .reset(reset), .iReadyToRead(iReadyToRead), .iMode(iMode),
    .iSolidRgb(iSolidRgb), .iNumFrames(iNumFrames), .iDsReady(iDsReady),
    .valid(valid), .lvalid(lvalid), .fvalid(fvalid), .sof(sof), .eof(eof), .rgb(rgb),
    .x(x), .y(y), .oBusy(oBusy), .oFrameCount(oFrameCount), .oDone(oDone));

  vfp_pattern_frame_gen #(.IMG_WIDTH(W8), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
                          .DATA_W(DW), .XY_W(XYW)) dut8 (
    .clkmm(clkmm), .reset(reset), .iReadyToRead(iReadyToRead), .iMode(iMode),
    .iSolidRgb(iSolidRgb), .iNumFrames(iNumFrames), .iDsReady(iDsReady),
    .valid(valid8), .lvalid(lvalid8), .fvalid(fvalid8), .sof(sof8), .eof(eof8), .rgb(rgb8),
    .x(x8), .y(y8), .oBusy(oBusy8), .oFrameCount(oFrameCount8), .oDone(oDone8));

  always #5 clkmm = ~clkmm;

  // pixel word: {x, y, rgb, sof, eof}
  logic [49:0] cap_w[$], exp_w[$];
  int fc_seq[$];
  int done_cnt, done_cyc, first_vld, held, proto_err;
  logic timed_out;

  // Reference pattern from the pixel coordinate and its index k within the run.
  function automatic logic [23:0] model_rgb(input int m, input int px, input int py,
                                            input int k, input logic [23:0] solid, input int w);
    logic [31:0] lf; logic [7:0] r, g, b; int c;
`ifndef VFP_PATGEN_LFSR_EN
    if (m == 3) m = 0;
`endif
    r = 8'h0; g = 8'h0; b = 8'h0; lf = SEED;
    case (m)
      0: begin r = 8'(px); g = 8'(py); b = 8'(px + py); end
      1: return solid;
      2: begin
        c = 7 - (px * 8) / w;
        r = (c & 4) != 0 ? 8'hFF : 8'h00;
        g = (c & 2) != 0 ? 8'hFF : 8'h00;
        b = (c & 1) != 0 ? 8'hFF : 8'h00;
      end
      3: begin
        for (int i = 0; i < k; i++) lf = lf[0] ? ((lf >> 1) ^ POLY) : (lf >> 1);
        return lf[23:0];
      end
      4: begin r = 8'(px); g = r; b = r; end
      5: if (((px / 8) % 2) != ((py / 8) % 2)) return 24'hFFFFFF;
      default: ;
    endcase
    return {r, g, b};
  endfunction

  task automatic build_exp(input int nfr, input int m_first, input int m_rest,
                           input logic [23:0] solid);
    int k;
    k = 0;
    exp_w.delete();
    for (int f = 0; f < nfr; f++)
      for (int yy = 0; yy < H; yy++)
        for (int xx = 0; xx < W; xx++) begin
          exp_w.push_back({12'(xx), 12'(yy),
                           model_rgb(f == 0 ? m_first : m_rest, xx, yy, k, solid, W),
                           xx == 0 && yy == 0, xx == W - 1 && yy == H - 1});
          k++;
        end
  endtask

  task automatic do_reset();
    @(negedge clkmm); reset = 1'b1; iReadyToRead = 1'b0; iDsReady = 1'b1;
    @(negedge clkmm); @(negedge clkmm); reset = 1'b0;
  endtask

  // Issue a start request and record every accepted pixel plus protocol anomalies.
  task automatic capture(input int max_cyc, input int stop_px, input int stall_pct,
                         input int sx, input int sy, input int slen,
                         input int chg_at, input logic [2:0] chg_mode);
    int left, tail; logic rdy, prev_stall; logic [49:0] prev_px; logic [15:0] last_fc;
    left = slen; tail = -1; prev_stall = 1'b0; prev_px = '0; last_fc = oFrameCount;
    cap_w.delete(); fc_seq.delete();
    done_cnt = 0; done_cyc = -1; first_vld = -1; held = 0; proto_err = 0; timed_out = 1'b1;
    iDsReady = 1'b1; iReadyToRead = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clkmm);
      iReadyToRead = 1'b0;
      if (oDone) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
      if (oFrameCount != last_fc) begin fc_seq.push_back(int'(oFrameCount)); last_fc = oFrameCount; end
      if (valid && first_vld < 0) first_vld = cyc;
      if (valid !== lvalid || (valid && !fvalid) || (valid && !oBusy) || (!valid && (sof || eof)))
        proto_err++;
      if (prev_stall && {x, y, rgb, sof, eof} !== prev_px) proto_err++;
      rdy = 1'b1;
      if (valid && int'(x) == sx && int'(y) == sy) begin
        held++;
        if (left > 0) begin rdy = 1'b0; left--; end
      end else if (valid && $urandom_range(99) < stall_pct) rdy = 1'b0;
      iDsReady = rdy;
      prev_stall = valid && !rdy;
      prev_px = {x, y, rgb, sof, eof};
      if (valid && rdy) begin
        cap_w.push_back({x, y, rgb, sof, eof});
        if (cap_w.size() == chg_at) iMode = chg_mode;
      end
      if (tail < 0 && ((stop_px > 0 && cap_w.size() >= stop_px) || (stop_px == 0 && done_cnt > 0)))
        tail = 12;
      if (tail == 0) begin timed_out = 1'b0; break; end
      if (tail > 0) tail--;
    end
    iDsReady = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clkmm); @(negedge clkmm);
    nchk++;
    if ({valid, lvalid, fvalid, sof, eof, rgb, x, y, oBusy, oFrameCount, oDone} !== '0) begin
      nfail++; $display("FAIL reset_outputs: got valid=%b rgb=%h x=%0d y=%0d busy=%b fc=%0d, want all zero",
                        valid, rgb, x, y, oBusy, oFrameCount);
    end
    nchk++;
    if ({valid8, lvalid8, fvalid8, sof8, eof8, rgb8, x8, y8, oBusy8, oFrameCount8, oDone8} !== '0) begin
      nfail++; $display("FAIL reset_outputs_w8: got valid=%b rgb=%h, want all zero", valid8, rgb8);
    end
    reset = 1'b0;
  endtask

  task automatic test_incrementer();
    do_reset(); iMode = 3'd0; iNumFrames = 16'd1; iSolidRgb = 24'($urandom);
    capture(200, 0, 0, -1, -1, 0, -1, 3'd0);
    build_exp(1, 0, 0, iSolidRgb);
    nchk++; if (timed_out) begin nfail++; $display("FAIL incr_timeout: no oDone within budget"); end
    nchk++; if (first_vld != 1) begin nfail++; $display("FAIL incr_latency: got %0d, want 1", first_vld); end
    nchk++; if (cap_w.size() != 8) begin nfail++; $display("FAIL incr_count: got %0d, want 8", cap_w.size()); end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      nchk++;
      if (cap_w[i] !== exp_w[i]) begin nfail++; $display("FAIL incr_px%0d: got %h, want %h", i, cap_w[i], exp_w[i]); end
    end
    nchk++;
    if (cap_w.size() > 4 && cap_w[4][25:2] !== 24'h000101) begin
      nfail++; $display("FAIL incr_px4_rgb: got %h, want 000101", cap_w[4][25:2]);
    end
    nchk++; if (done_cyc - first_vld != 15) begin nfail++; $display("FAIL incr_frame_period: got %0d, want 15", done_cyc - first_vld); end
    nchk++; if (done_cnt != 1) begin nfail++; $display("FAIL incr_done_pulses: got %0d, want 1", done_cnt); end
    nchk++; if (oFrameCount !== 16'd1) begin nfail++; $display("FAIL incr_framecount: got %0d, want 1", oFrameCount); end
    nchk++; if (oBusy !== 1'b0) begin nfail++; $display("FAIL incr_busy_idle: got %b, want 0", oBusy); end
    nchk++; if (proto_err != 0) begin nfail++; $display("FAIL incr_protocol: got %0d errors, want 0", proto_err); end
  endtask

  task automatic test_stall();
    do_reset(); iMode = 3'd1; iNumFrames = 16'd1; iSolidRgb = 24'h123456;
    capture(200, 0, 0, 2, 0, 3, -1, 3'd0);
    build_exp(1, 1, 1, 24'h123456);
    nchk++; if (timed_out) begin nfail++; $display("FAIL stall_timeout: no oDone within budget"); end
    nchk++; if (held != 4) begin nfail++; $display("FAIL stall_held: got %0d cycles at (2,0), want 4", held); end
    nchk++; if (cap_w.size() != 8) begin nfail++; $display("FAIL stall_count: got %0d, want 8", cap_w.size()); end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      nchk++;
      if (cap_w[i] !== exp_w[i]) begin nfail++; $display("FAIL stall_px%0d: got %h, want %h", i, cap_w[i], exp_w[i]); end
    end
    nchk++; if (done_cyc - first_vld != 18) begin nfail++; $display("FAIL stall_frame_period: got %0d, want 18", done_cyc - first_vld); end
    nchk++; if (proto_err != 0) begin nfail++; $display("FAIL stall_protocol: got %0d errors, want 0", proto_err); end
  endtask

  task automatic test_bars();
    logic [23:0] want[8]; logic [23:0] got[8]; int gx[8]; int n;
    want = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
             24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};
    do_reset(); iMode = 3'd2; iNumFrames = 16'd1; iDsReady = 1'b1; iReadyToRead = 1'b1; n = 0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      @(negedge clkmm); iReadyToRead = 1'b0;
      if (valid8 && y8 == '0) begin got[n] = rgb8; gx[n] = int'(x8); n++; end
    end
    nchk++; if (n != 8) begin nfail++; $display("FAIL bars_count: got %0d, want 8", n); end
    for (int i = 0; i < n; i++) begin
      nchk++;
      if (gx[i] != i || got[i] !== want[i]) begin
        nfail++; $display("FAIL bars_x%0d: got x=%0d %h, want x=%0d %h", i, gx[i], got[i], i, want[i]);
      end
    end
  endtask

  task automatic test_continuous();
    do_reset(); iMode = 3'd0; iNumFrames = 16'd0;
    capture(400, 24, 0, -1, -1, 0, 3, 3'd4);
    build_exp(3, 0, 4, iSolidRgb);
    nchk++; if (timed_out) begin nfail++; $display("FAIL cont_timeout: 24 pixels not seen"); end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      nchk++;
      if (cap_w[i] !== exp_w[i]) begin nfail++; $display("FAIL cont_px%0d: got %h, want %h", i, cap_w[i], exp_w[i]); end
    end
    nchk++; if (done_cnt != 0) begin nfail++; $display("FAIL cont_no_done: got %0d pulses, want 0", done_cnt); end
    nchk++;
    if (fc_seq.size() < 3 || fc_seq[0] != 1 || fc_seq[1] != 2 || fc_seq[2] != 3) begin
      nfail++; $display("FAIL cont_framecount: got %0d values first=%0d, want 1,2,3", fc_seq.size(),
                        fc_seq.size() > 0 ? fc_seq[0] : -1);
    end
    nchk++; if (oBusy !== 1'b1) begin nfail++; $display("FAIL cont_busy: got %b, want 1", oBusy); end
    iMode = 3'd0;
  endtask

  task automatic test_mid_reset();
    logic hit; int eofs;
    do_reset(); iMode = 3'd0; iNumFrames = 16'd0; iReadyToRead = 1'b1; hit = 1'b0; eofs = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clkmm); iReadyToRead = 1'b0;
      if (valid && eof) eofs++;
      if (valid && x == 12'd1 && y == 12'd1) begin hit = 1'b1; break; end
    end
    nchk++; if (!hit) begin nfail++; $display("FAIL midrst_reach: pixel (1,1) not reached"); end
    reset = 1'b1;
    @(negedge clkmm);
    nchk++;
    if ({valid, lvalid, fvalid, sof, eof, rgb, x, y, oBusy, oFrameCount, oDone} !== '0) begin
      nfail++; $display("FAIL midrst_outputs: got valid=%b rgb=%h x=%0d y=%0d busy=%b, want all zero",
                        valid, rgb, x, y, oBusy);
    end
    nchk++; if (eofs != 0) begin nfail++; $display("FAIL midrst_eof: got %0d eof pixels, want 0", eofs); end
    reset = 1'b0; iReadyToRead = 1'b1;
    @(negedge clkmm); iReadyToRead = 1'b0;
    nchk++;
    if ({valid, x, y, sof} !== {1'b1, 12'd0, 12'd0, 1'b1}) begin
      nfail++; $display("FAIL midrst_restart: got valid=%b x=%0d y=%0d sof=%b, want 1 0 0 1", valid, x, y, sof);
    end
  endtask

  task automatic test_lfsr_mode();
    logic [23:0] want0;
`ifdef VFP_PATGEN_LFSR_EN
    want0 = 24'hE12468;
`else
    want0 = 24'h000000;
`endif
    do_reset(); iMode = 3'd3; iNumFrames = 16'd1;
    capture(200, 0, 0, -1, -1, 0, -1, 3'd0);
    build_exp(1, 3, 3, iSolidRgb);
    nchk++; if (timed_out) begin nfail++; $display("FAIL lfsr_timeout: no oDone within budget"); end
    nchk++;
    if (cap_w.size() == 0 || cap_w[0][25:2] !== want0) begin
      nfail++; $display("FAIL lfsr_first: got %h, want %h", cap_w.size() > 0 ? cap_w[0][25:2] : 24'hx, want0);
    end
    for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
      nchk++;
      if (cap_w[i] !== exp_w[i]) begin nfail++; $display("FAIL lfsr_px%0d: got %h, want %h", i, cap_w[i], exp_w[i]); end
    end
  endtask

  // Random modes/colours with random backpressure, runs started back to back.
  task automatic test_back_to_back();
    int m;
    do_reset();
    for (int it = 0; it < 5; it++) begin
      m = int'($urandom_range(7)); iMode = 3'(m); iSolidRgb = 24'($urandom); iNumFrames = 16'd2;
      capture(600, 0, 30, -1, -1, 0, -1, 3'd0);
      build_exp(2, m, m, iSolidRgb);
      nchk++; if (timed_out) begin nfail++; $display("FAIL rand%0d_timeout: no oDone within budget", it); end
      nchk++; if (first_vld != 1) begin nfail++; $display("FAIL rand%0d_latency: got %0d, want 1", it, first_vld); end
      nchk++; if (cap_w.size() != 16) begin nfail++; $display("FAIL rand%0d_count: got %0d, want 16", it, cap_w.size()); end
      for (int i = 0; i < exp_w.size() && i < cap_w.size(); i++) begin
        nchk++;
        if (cap_w[i] !== exp_w[i]) begin
          nfail++; $display("FAIL rand%0d_px%0d mode%0d: got %h, want %h", it, i, m, cap_w[i], exp_w[i]);
        end
      end
      nchk++; if (done_cnt != 1) begin nfail++; $display("FAIL rand%0d_done: got %0d, want 1", it, done_cnt); end
      nchk++;
      if (fc_seq.size() == 0 || fc_seq[fc_seq.size()-1] != 2) begin
        nfail++; $display("FAIL rand%0d_framecount: got %0d, want 2", it, oFrameCount);
      end
      nchk++; if (proto_err != 0) begin nfail++; $display("FAIL rand%0d_protocol: got %0d errors, want 0", it, proto_err); end
    end
  endtask

  initial begin
    test_reset();
    test_incrementer();
    test_stall();
    test_bars();
    test_continuous();
    test_mid_reset();
    test_lfsr_mode();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vfp_pattern_frame_gen.md
# vfp_pattern_frame_gen

Parametrised video test-pattern source for the VFP pipeline. It generates complete raster frames of configurable size, blanking and pixel depth on the `pattern_channel` signal set: `valid`, `lvalid`, `fvalid`, `sof`, `eof`, `rgb`, `x`, `y`. Six selectable patterns are supported, plus downstream backpressure and a bounded or continuous frame count. It replaces the fixed 8-bit, fixed-size pattern stimulus and drives the VFP input in both simulation and on-target bring-up.

## Interface
- IMG_WIDTH, 1920: active pixels per line (>=2)
- IMG_HEIGHT, 1080: active lines per frame (>=1)
- H_BLANK, 16: idle cycles after each line (>=1)
- V_BLANK, 32: idle cycles after last line's H_BLANK (>=1)
- DATA_W, 8: bits per colour channel
- XY_W, 12: coordinate width; must satisfy 2^XY_W >= max(IMG_WIDTH, IMG_HEIGHT)
- clkmm  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- iReadyToRead  in  1  start request, sampled in IDLE
- iMode  in  3  pattern select, latched at each frame start
- iSolidRgb  in  3*DATA_W  solid colour {R,G,B}
- iNumFrames  in  16  frames per run; 0 = continuous
- iDsReady  in  1  downstream ready; pixel transfers when valid&&iDsReady
- valid, lvalid, fvalid, sof, eof  out  1 each
- rgb  out  3*DATA_W  {red,green,blue}
- x, y  out  XY_W  coordinates of current pixel
- oBusy  out  1  high outside IDLE/DONE
- oFrameCount  out  16  completed frames this run
- oDone  out  1  one-cycle pulse at run completion

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK, DONE.
- IDLE: all outputs 0. iReadyToRead=1 latches iNumFrames, clears oFrameCount, seeds LFSR, latches iMode, -> ACTIVE with x=y=0.
- ACTIVE: valid=lvalid=fvalid=1. On transfer, x increments. At x=IMG_WIDTH-1 transfer -> HBLANK.
- valid && !iDsReady: x, y, rgb, sof, eof, LFSR held (stall); state unchanged.
- HBLANK: valid=lvalid=0, fvalid=1, H_BLANK cycles, no stall. Then y+1 and x=0 -> ACTIVE, or, if the last line completed, -> VBLANK.
- VBLANK: fvalid=0, V_BLANK cycles. oFrameCount+1 on entry. At exit:
  - if iNumFrames!=0 and oFrameCount==latched count -> DONE;
  - else relatch iMode -> ACTIVE.
- DONE: one cycle, oDone=1 -> IDLE.
- sof=1 only with pixel (0,0); eof=1 only with pixel (IMG_WIDTH-1, IMG_HEIGHT-1); both held through stalls.
- Patterns (DATA_W-bit truncation of all sums):
  - 0 incrementer: R=x, G=y, B=x+y.
  - 1 solid: iSolidRgb.
  - 2 colour bars: bar i = floor(x*8/IMG_WIDTH), c=7-i, each channel all-ones if its bit of c is set (R=c[2], G=c[1], B=c[0]).
  - 3 random: LFSR[3*DATA_W-1:0].
  - 4 grey ramp: R=G=B=x.
  - 5 checkerboard: all-ones when x[3]^y[3], else 0.
  - 6, 7: black.
- Bar thresholds are precomputed constants; no runtime divider.
- LFSR: 32-bit Galois, polynomial 0x80200003, seed 0xACE12468. Advances on each transfer. For DATA_W>10, LFSR output is replicated.
- oFrameCount wraps at 16 bits in continuous mode.
- Reset in any state -> IDLE next edge; partial frame is abandoned with no eof.

## Timing
- Reset values: all outputs 0, LFSR = seed.
- Latency: first valid pixel is the cycle after iReadyToRead is sampled high in IDLE.
- All outputs are registered.
- Line period with iDsReady=1: IMG_WIDTH+H_BLANK cycles.
- Frame period with iDsReady=1: IMG_HEIGHT*(IMG_WIDTH+H_BLANK)+V_BLANK cycles.
- iMode changes mid-frame have no effect until the next frame start.
- iReadyToRead is ignored outside IDLE.

## Configuration
- VFP_PATGEN_LFSR_EN defined: mode 3 is random, LFSR logic present.
- Not defined: LFSR removed; mode 3 produces the incrementer pattern.

## Test plan
- Setup for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=2, H_BLANK=2, V_BLANK=3, DATA_W=8, iDsReady=1.
- Mode 0, iNumFrames=1 -> pixels (0,0)..(3,1) with rgb 000000,010001,020002,030003,000101..030104; sof on first, eof on last; frame 15 cycles; oDone one pulse; oFrameCount=1.
- Mode 1, iSolidRgb=0x123456, iDsReady low 3 cycles at pixel (2,0) -> pixel (2,0) held 3 extra cycles; no duplicates or drops; 8 transfers total.
- Mode 2, IMG_WIDTH=8 -> x=0..7 give FFFFFF, FFFF00, FF00FF, FF0000, 00FFFF, 00FF00, 0000FF, 000000.
- iNumFrames=0, iMode changed 0->4 mid-frame 1 -> frame 1 stays incrementer, frame 2 is grey ramp; oFrameCount 1, 2, 3...; no oDone.
- reset asserted at pixel (1,1) -> all outputs 0 next cycle; new iReadyToRead restarts at (0,0) with sof.
- Mode 3 with VFP_PATGEN_LFSR_EN -> first pixel rgb = seed[23:0] = E12468. Without the macro -> 000000.
